// File: rtl/sd_fifo_arb.sv
// sd_fifo_arb: round-robin srdy/drdy arbiter feeding one sd_fifo_c, with a usage high-watermark throttle.
// Optional packet lock (bit width-1 = EOP) when SD_FIFO_ARB_LOCK_EN is defined.
`default_nettype none

module sd_fifo_arb #(
  parameter int                width     = 16,
  parameter int                inputs    = 4,
  parameter int                depth     = 8,
  parameter int                usz       = $clog2(depth + 1),
  parameter int                hiwat     = 6,
  parameter logic [inputs-1:0] prio_mask = 'b0001,
  parameter int                isz       = $clog2(inputs)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  input  logic [usz-1:0]          usage,
  output logic [isz-1:0]          grant_idx,
  output logic                    throttled
);

  localparam logic [isz:0]   n_in     = (isz + 1)'(inputs);
  localparam logic [isz-1:0] last_idx = isz'(inputs - 1);
  localparam logic [usz-1:0] hiwat_u  = usz'(hiwat);

  logic [isz-1:0]    rr_ptr;
  logic              hold_vld;
  logic [isz-1:0]    hold_idx;
  logic [inputs-1:0] elig;
  logic              found;
  logic [isz-1:0]    win;
  logic [isz:0]      idx;
  logic [isz-1:0]    nxt_ptr;
  logic              xfer;
`ifdef SD_FIFO_ARB_LOCK_EN
  logic              lock_vld;
  logic [isz-1:0]    lock_idx;
`endif

  always_comb begin
    elig  = c_srdy & ({inputs{~throttled}} | prio_mask);
    found = 1'b0;
    win   = rr_ptr;
    idx   = '0;
    for (int k = 0; k < inputs; k++) begin
      idx = {1'b0, rr_ptr} + (isz + 1)'(k);
      if (idx >= n_in) idx = idx - n_in;
      if (!found && elig[idx[isz-1:0]]) begin
        found = 1'b1;
        win   = idx[isz-1:0];
      end
    end
    // A stalled winner keeps its grant while its srdy stays up, even if throttled meanwhile.
    if (hold_vld && c_srdy[hold_idx]) begin
      found = 1'b1;
      win   = hold_idx;
    end
`ifdef SD_FIFO_ARB_LOCK_EN
    if (lock_vld) begin
      found = c_srdy[lock_idx];
      win   = found ? lock_idx : rr_ptr;
    end
`endif
  end

  always_comb begin
    p_srdy      = found;
    grant_idx   = win;
    p_data      = found ? c_data[win*width +: width] : '0;
    c_drdy      = '0;
    c_drdy[win] = found & p_drdy & ~reset;
    xfer        = found & p_drdy & ~reset;
    nxt_ptr     = (win == last_idx) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      throttled <= 1'b0;
      hold_vld  <= 1'b0;
      hold_idx  <= '0;
`ifdef SD_FIFO_ARB_LOCK_EN
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
`endif
    end else begin
      throttled <= (usage >= hiwat_u);
      hold_vld  <= found & ~p_drdy;
      hold_idx  <= win;
      if (xfer) begin
`ifdef SD_FIFO_ARB_LOCK_EN
        if (p_data[width-1]) begin
          lock_vld <= 1'b0;
          rr_ptr   <= nxt_ptr;
        end else begin
          lock_vld <= 1'b1;
          lock_idx <= win;
        end
`else
        rr_ptr <= nxt_ptr;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_fifo_arb.sv
// Directed bench for sd_fifo_arb: a 4-input instance and a 3-input instance sharing clk/reset.
`default_nettype none

module tb_sd_fifo_arb;

`ifdef SD_FIFO_ARB_LOCK_EN
  localparam logic [15:0] EOP = 16'h8000;
`else
  localparam logic [15:0] EOP = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  c_srdy, c_drdy;
  logic [63:0] c_data;
  logic        p_srdy, p_drdy;
  logic [15:0] p_data;
  logic [3:0]  usage;
  logic [1:0]  grant_idx;
  logic        throttled;

  logic [2:0]  c_srdy3, c_drdy3;
  logic [47:0] c_data3;
  logic        p_srdy3, p_drdy3;
  logic [15:0] p_data3;
  logic [3:0]  usage3;
  logic [1:0]  grant_idx3;
  logic        throttled3;

  int tests = 0;
  int fails = 0;

  sd_fifo_arb dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .usage(usage),
    .grant_idx(grant_idx), .throttled(throttled)
  );

  sd_fifo_arb #(.inputs(3), .prio_mask(3'b001)) dut3 (
    .clk(clk), .reset(reset), .c_srdy(c_srdy3), .c_drdy(c_drdy3), .c_data(c_data3),
    .p_srdy(p_srdy3), .p_drdy(p_drdy3), .p_data(p_data3), .usage(usage3),
    .grant_idx(grant_idx3), .throttled(throttled3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp4[6];
    int exp3[7];
    exp4 = '{0, 1, 2, 3, 0, 1};
    exp3 = '{0, 1, 2, 0, 1, 2, 0};

    reset = 1'b1; c_srdy = '0; c_data = '0; p_drdy = 1'b0; usage = '0;
    c_srdy3 = '0; c_data3 = '0; p_drdy3 = 1'b0; usage3 = '0;
    tick(); tick();

    // reset state with everything requesting
    c_srdy = 4'hF; p_drdy = 1'b1;
    for (int i = 0; i < 4; i++) c_data[i*16 +: 16] = EOP | 16'h0100 | 16'(i);
    #1;
    chk("rst_cdrdy", 32'(c_drdy), 32'h0);
    chk("rst_throttled", 32'(throttled), 32'h0);
    reset = 1'b0;
    #1;

    // all four requesting: 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", 32'(grant_idx), 32'(exp4[k]));
      chk("rr_cdrdy", 32'(c_drdy), 32'(4'b0001 << exp4[k]));
      chk("rr_pdata", 32'(p_data), 32'(EOP | 16'h0100 | 16'(exp4[k])));
      tick();
    end

    // single requester stalled by a full FIFO for 3 cycles
    c_srdy = 4'b0100; p_drdy = 1'b0; c_data[32 +: 16] = EOP | 16'h00A5;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_grant", 32'(grant_idx), 32'd2);
      chk("stall_psrdy", 32'(p_srdy), 32'd1);
      chk("stall_cdrdy", 32'(c_drdy), 32'h0);
      chk("stall_pdata", 32'(p_data), 32'(EOP | 16'h00A5));
      tick();
    end
    p_drdy = 1'b1;
    #1;
    chk("stall_release_cdrdy", 32'(c_drdy), 32'h4);
    chk("stall_release_grant", 32'(grant_idx), 32'd2);
    tick();

    // watermark throttle: rr_ptr=3, inputs 0 and 3 requesting
    c_srdy = 4'b1001; usage = 4'd6;
    #1;
    chk("thr_pre_grant", 32'(grant_idx), 32'd3);
    chk("thr_pre_flag", 32'(throttled), 32'd0);
    tick();
    chk("thr_on_flag", 32'(throttled), 32'd1);
    chk("thr_on_grant", 32'(grant_idx), 32'd0);
    tick();
    chk("thr_on_grant2", 32'(grant_idx), 32'd0);
    usage = 4'd5;
    tick();
    chk("thr_off_flag", 32'(throttled), 32'd0);
    chk("thr_off_grant", 32'(grant_idx), 32'd3);

    // reset while input 1 is granted with rr_ptr=2
    usage = 4'd0; c_srdy = 4'b0010;
    tick();
    chk("mid_grant", 32'(grant_idx), 32'd1);
    chk("mid_cdrdy", 32'(c_drdy), 32'h2);
    reset = 1'b1; usage = 4'd7;
    #1;
    chk("mid_rst_cdrdy", 32'(c_drdy), 32'h0);
    tick();
    reset = 1'b0; usage = 4'd0; c_srdy = 4'b1010;
    #1;
    chk("post_rst_throttled", 32'(throttled), 32'd0);
    chk("post_rst_grant", 32'(grant_idx), 32'd1);

    // a stalled winner is not displaced by a later requester nearer rr_ptr
    tick();
    c_srdy = 4'b0001; p_drdy = 1'b0;
    #1;
    chk("hold_first", 32'(grant_idx), 32'd0);
    tick();
    c_srdy = 4'b1001;
    #1;
    chk("hold_keep", 32'(grant_idx), 32'd0);
    p_drdy = 1'b1;
    tick();
    chk("hold_after", 32'(grant_idx), 32'd3);

    // three-input instance: wrap 2 -> 0
    c_srdy3 = 3'b111; p_drdy3 = 1'b1;
    for (int i = 0; i < 3; i++) c_data3[i*16 +: 16] = EOP | 16'h0300 | 16'(i);
    #1;
    for (int k = 0; k < 7; k++) begin
      chk("rr3_grant", 32'(grant_idx3), 32'(exp3[k]));
      chk("rr3_pdata", 32'(p_data3), 32'(EOP | 16'h0300 | 16'(exp3[k])));
      tick();
    end

`ifdef SD_FIFO_ARB_LOCK_EN
    // packet lock: input 1 sends 3 words with a gap while input 0 waits
    reset = 1'b1; c_srdy = '0;
    tick();
    reset = 1'b0; c_srdy = 4'b0001; p_drdy = 1'b1;
    #1;
    chk("lk_setup", 32'(grant_idx), 32'd0);
    tick();
    c_srdy = 4'b0011; c_data[16 +: 16] = 16'h0011;
    #1;
    chk("lk_w0", 32'(grant_idx), 32'd1);
    tick();
    c_data[16 +: 16] = 16'h0012;
    #1;
    chk("lk_w1", 32'(grant_idx), 32'd1);
    chk("lk_w1_cdrdy", 32'(c_drdy), 32'h2);
    tick();
    c_srdy = 4'b0001;
    #1;
    chk("lk_gap_psrdy", 32'(p_srdy), 32'd0);
    chk("lk_gap_cdrdy", 32'(c_drdy), 32'h0);
    tick();
    c_srdy = 4'b0011; c_data[16 +: 16] = 16'h8013;
    #1;
    chk("lk_w2", 32'(grant_idx), 32'd1);
    tick();
    chk("lk_release_grant", 32'(grant_idx), 32'd0);
    chk("lk_release_cdrdy", 32'(c_drdy), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
